// File: rtl/ct_pkg.sv
// Shared types and constants for the programmable modulo counter and its BCD splitter.
package ct_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t        BCD_BLANK = 4'hF;
  localparam int unsigned MIN_MOD   = 2;

  typedef enum logic {DIR_DN = 1'b0, DIR_UP = 1'b1} ct_dir_e;
  typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} ct_mode_e;

endpackage

// File: rtl/ct_bcd_split.sv
// Binary to tens/ones digits for the display; values above 99 show as blank on both digits.
module ct_bcd_split
  import ct_pkg::*;
#(
  parameter int unsigned W = 7
) (
  input  logic [W-1:0] bin_i,
  output bcd_t         tens_o,
  output bcd_t         ones_o
);

  logic [31:0] bin32;

  always_comb begin
    bin32  = 32'(bin_i);
    tens_o = BCD_BLANK;
    ones_o = BCD_BLANK;
    if (bin32 <= 32'd99) begin
      tens_o = bcd_t'(bin32 / 32'd10);
      ones_o = bcd_t'(bin32 % 32'd10);
    end
  end

endmodule

// File: rtl/ct_mod_prog.sv
// Programmable-modulus up/down counter with load, wrap/saturate, cascade carry and BCD outputs.
module ct_mod_prog
  import ct_pkg::*;
#(
  parameter int unsigned W = 7,
  parameter int unsigned N = 60
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         sat,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         mod_wr,
  input  logic [W-1:0] mod_val,
  output logic [W-1:0] ct_out,
  output logic [W-1:0] mod_q,
  output logic         z,
  output logic         cy,
  output logic         err,
  output bcd_t         bcd_tens,
  output bcd_t         bcd_ones
);

  localparam logic [W:0] NExt   = (W + 1)'(N);
  localparam logic [W:0] MinMod = (W + 1)'(MIN_MOD);
  localparam logic [W:0] One    = (W + 1)'(1);

  logic [W-1:0] ct_q, ct_d;
  logic [W-1:0] modulus_q, modulus_d;
  logic         err_q, err_d;

  logic [W:0] ct_ext, mod_ext, mod_val_ext, ld_ext, eff_mod;
  logic       mod_legal;
  ct_dir_e    dir;
  ct_mode_e   mode;

  always_comb begin
    dir         = ct_dir_e'(up);
    mode        = ct_mode_e'(sat);
    ct_ext      = {1'b0, ct_q};
    // A stored zero can only come from N == 2^W, so it stands for the full range.
    mod_ext     = (modulus_q == '0) ? {1'b1, {W{1'b0}}} : {1'b0, modulus_q};
    mod_val_ext = {1'b0, mod_val};
    ld_ext      = {1'b0, ld_val};
    mod_legal   = (mod_val_ext >= MinMod);
    eff_mod     = (mod_wr && mod_legal) ? mod_val_ext : mod_ext;
    z           = (dir == DIR_UP) ? (ct_ext == mod_ext - One) : (ct_ext == '0);
    cy          = en & z & (mode == MODE_WRAP) & ~ld & ~mod_wr & ~rst;
  end

  always_comb begin
    ct_d      = ct_q;
    modulus_d = modulus_q;
    err_d     = 1'b0;
    if (rst) begin
      ct_d      = '0;
      modulus_d = NExt[W-1:0];
    end else begin
      if (mod_wr) begin
        if (!mod_legal) begin
          err_d = 1'b1;
        end else begin
          modulus_d = mod_val;
          if (ct_ext >= mod_val_ext) ct_d = '0;
        end
      end
      if (ld) begin
        if (ld_ext < eff_mod) begin
          ct_d = ld_val;
        end else begin
          ct_d  = W'(eff_mod - One);
          err_d = 1'b1;
        end
      end else if (!mod_wr && en) begin
        if (dir == DIR_UP) begin
          if (!z)                     ct_d = W'(ct_ext + One);
          else if (mode == MODE_WRAP) ct_d = '0;
        end else begin
          if (!z)                     ct_d = W'(ct_ext - One);
          else if (mode == MODE_WRAP) ct_d = W'(mod_ext - One);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    ct_q      <= ct_d;
    modulus_q <= modulus_d;
    err_q     <= err_d;
  end

  assign ct_out = ct_q;
  assign mod_q  = modulus_q;
  assign err    = err_q;

  ct_bcd_split #(
    .W(W)
  ) u_bcd (
    .bin_i (ct_q),
    .tens_o(bcd_tens),
    .ones_o(bcd_ones)
  );

endmodule

// File: tb/tb_ct_mod_prog.sv
// Directed bench for ct_mod_prog: single counter, a sec/min/hour cascade and an 8-bit instance.
module tb_ct_mod_prog;
  import ct_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (W=7, N=60)
  logic       rst0, en, up, sat, ld, mod_wr;
  logic [6:0] ld_val, mod_val;
  logic [6:0] ct_out, mod_q;
  logic       z, cy, err;
  bcd_t       tens, ones;

  ct_mod_prog #(.W(7), .N(60)) u0 (
    .clk(clk), .rst(rst0), .en(en), .up(up), .sat(sat), .ld(ld), .ld_val(ld_val),
    .mod_wr(mod_wr), .mod_val(mod_val), .ct_out(ct_out), .mod_q(mod_q), .z(z), .cy(cy),
    .err(err), .bcd_tens(tens), .bcd_ones(ones)
  );

  // Cascade: seconds -> minutes -> hours
  logic       rst_c, c_en;
  logic [6:0] s_ct, m_ct, h_ct, s_mod, m_mod, h_mod;
  logic       s_z, m_z, h_z, s_cy, m_cy, h_cy, s_err, m_err, h_err;
  bcd_t       s_t, s_o, m_t, m_o, h_t, h_o;

  ct_mod_prog #(.W(7), .N(60)) u_sec (
    .clk(clk), .rst(rst_c), .en(c_en), .up(1'b1), .sat(1'b0), .ld(1'b0), .ld_val(7'd0),
    .mod_wr(1'b0), .mod_val(7'd0), .ct_out(s_ct), .mod_q(s_mod), .z(s_z), .cy(s_cy),
    .err(s_err), .bcd_tens(s_t), .bcd_ones(s_o)
  );
  ct_mod_prog #(.W(7), .N(60)) u_min (
    .clk(clk), .rst(rst_c), .en(s_cy), .up(1'b1), .sat(1'b0), .ld(1'b0), .ld_val(7'd0),
    .mod_wr(1'b0), .mod_val(7'd0), .ct_out(m_ct), .mod_q(m_mod), .z(m_z), .cy(m_cy),
    .err(m_err), .bcd_tens(m_t), .bcd_ones(m_o)
  );
  ct_mod_prog #(.W(7), .N(24)) u_hr (
    .clk(clk), .rst(rst_c), .en(m_cy), .up(1'b1), .sat(1'b0), .ld(1'b0), .ld_val(7'd0),
    .mod_wr(1'b0), .mod_val(7'd0), .ct_out(h_ct), .mod_q(h_mod), .z(h_z), .cy(h_cy),
    .err(h_err), .bcd_tens(h_t), .bcd_ones(h_o)
  );

  // Wide instance (W=8, N=200)
  logic       rst8, ld8;
  logic [7:0] ld_val8, ct8, mod8;
  logic       z8, cy8, err8;
  bcd_t       tens8, ones8;

  ct_mod_prog #(.W(8), .N(200)) u8 (
    .clk(clk), .rst(rst8), .en(1'b0), .up(1'b1), .sat(1'b0), .ld(ld8), .ld_val(ld_val8),
    .mod_wr(1'b0), .mod_val(8'd0), .ct_out(ct8), .mod_q(mod8), .z(z8), .cy(cy8),
    .err(err8), .bcd_tens(tens8), .bcd_ones(ones8)
  );

  typedef enum int {
    S_CT, S_MOD, S_Z, S_CY, S_ERR, S_TENS, S_ONES,
    C_S_CT, C_M_CT, C_H_CT, C_S_CY, C_M_CY,
    B_CT, B_MOD, B_ERR, B_TENS, B_ONES
  } sig_e;

  typedef struct {
    string       tag;
    sig_e        sig;
    int unsigned val;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic logic [31:0] obs(sig_e s);
    case (s)
      S_CT:    return 32'(ct_out);
      S_MOD:   return 32'(mod_q);
      S_Z:     return 32'(z);
      S_CY:    return 32'(cy);
      S_ERR:   return 32'(err);
      S_TENS:  return 32'(tens);
      S_ONES:  return 32'(ones);
      C_S_CT:  return 32'(s_ct);
      C_M_CT:  return 32'(m_ct);
      C_H_CT:  return 32'(h_ct);
      C_S_CY:  return 32'(s_cy);
      C_M_CY:  return 32'(m_cy);
      B_CT:    return 32'(ct8);
      B_MOD:   return 32'(mod8);
      B_ERR:   return 32'(err8);
      B_TENS:  return 32'(tens8);
      B_ONES:  return 32'(ones8);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input sig_e s, input int unsigned v);
    sb.push_back('{tag, s, v});
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sig);
      n_chk++;
      assert (o === 32'(e.val)) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", e.tag, o, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst0 = 1'b1; en = 1'b1; up = 1'b0; sat = 1'b0; ld = 1'b0; mod_wr = 1'b0;
    ld_val = '0; mod_val = '0;
    rst_c = 1'b1; c_en = 1'b0;
    rst8 = 1'b1; ld8 = 1'b0; ld_val8 = '0;

    // Reset state; en=1/up=0 would carry at 0, but rst masks cy
    tick();
    push("rst_ct", S_CT, 0); push("rst_mod", S_MOD, 60); push("rst_err", S_ERR, 0);
    push("rst_z", S_Z, 1); push("rst_cy", S_CY, 0);
    push("rst8_ct", B_CT, 0); push("rst8_mod", B_MOD, 200);
    drain();

    // Count up through a full period
    rst0 = 1'b0; rst8 = 1'b0; up = 1'b1;
    #1;
    for (int i = 0; i < 60; i++) begin
      push($sformatf("up_ct%0d", i), S_CT, i);
      push($sformatf("up_z%0d", i), S_Z, (i == 59) ? 1 : 0);
      push($sformatf("up_cy%0d", i), S_CY, (i == 59) ? 1 : 0);
      push($sformatf("up_tens%0d", i), S_TENS, i / 10);
      push($sformatf("up_ones%0d", i), S_ONES, i % 10);
      drain();
      tick();
    end
    push("up_wrap", S_CT, 0); drain();

    // Down from 0 wraps to 59 with a borrow pulse
    up = 1'b0; #1;
    push("dn_z0", S_Z, 1); push("dn_cy0", S_CY, 1); drain();
    tick();
    push("dn_wrap", S_CT, 59); drain();

    en = 1'b0; ld = 1'b1; ld_val = 7'd0; tick(); ld = 1'b0;
    push("ld0_ct", S_CT, 0); push("ld0_err", S_ERR, 0); drain();

    // Saturating down holds at 0 with no borrow
    sat = 1'b1; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      push($sformatf("sat_cy%0d", i), S_CY, 0); push($sformatf("sat_z%0d", i), S_Z, 1);
      drain();
      tick();
      push($sformatf("sat_ct%0d", i), S_CT, 0); drain();
    end
    sat = 1'b0; en = 1'b0;

    // Modulus shrink below current count clears the count
    ld = 1'b1; ld_val = 7'd45; tick(); ld = 1'b0;
    push("ld45", S_CT, 45); drain();
    mod_wr = 1'b1; mod_val = 7'd24; en = 1'b1; up = 1'b1; tick(); mod_wr = 1'b0; en = 1'b0;
    push("mw24_mod", S_MOD, 24); push("mw24_ct", S_CT, 0); push("mw24_err", S_ERR, 0); drain();
    mod_wr = 1'b1; mod_val = 7'd1; tick(); mod_wr = 1'b0;
    push("mw1_err", S_ERR, 1); push("mw1_mod", S_MOD, 24); push("mw1_ct", S_CT, 0); drain();
    tick();
    push("mw1_err_clr", S_ERR, 0); drain();

    // Out-of-range load clamps to M-1; load beats count
    ld = 1'b1; ld_val = 7'd30; en = 1'b1; tick();
    push("ld30_ct", S_CT, 23); push("ld30_err", S_ERR, 1); drain();
    ld_val = 7'd12; tick();
    push("ld12_ct", S_CT, 12); push("ld12_err", S_ERR, 0); drain();
    ld = 1'b0; en = 1'b0;

    // Load checked against a legal modulus written in the same cycle
    mod_wr = 1'b1; mod_val = 7'd10; ld = 1'b1; ld_val = 7'd15; tick();
    mod_wr = 1'b0; ld = 1'b0;
    push("mwld_mod", S_MOD, 10); push("mwld_ct", S_CT, 9); push("mwld_err", S_ERR, 1); drain();

    // z follows direction combinationally
    up = 1'b1; #1; push("z_up9", S_Z, 1); drain();
    up = 1'b0; #1; push("z_dn9", S_Z, 0); drain();

    // Back-to-back illegal writes keep err high
    mod_wr = 1'b1; mod_val = 7'd0; tick();
    push("bb_err1", S_ERR, 1); drain();
    tick();
    push("bb_err2", S_ERR, 1); push("bb_mod", S_MOD, 10); drain();
    mod_wr = 1'b0; tick();
    push("bb_err_clr", S_ERR, 0); drain();

    // Cascade over one hour
    rst_c = 1'b0; c_en = 1'b1;
    repeat (3599) tick();
    push("c3599_s", C_S_CT, 59); push("c3599_m", C_M_CT, 59); push("c3599_h", C_H_CT, 0);
    push("c3599_scy", C_S_CY, 1); push("c3599_mcy", C_M_CY, 1); drain();
    tick();
    push("c3600_s", C_S_CT, 0); push("c3600_m", C_M_CT, 0); push("c3600_h", C_H_CT, 1); drain();
    repeat (100) tick();
    rst_c = 1'b1; tick();
    push("crst_s", C_S_CT, 0); push("crst_m", C_M_CT, 0); push("crst_h", C_H_CT, 0);
    push("crst_scy", C_S_CY, 0); drain();

    // BCD blanking on the 8-bit instance
    ld8 = 1'b1; ld_val8 = 8'd150; tick();
    push("b150_ct", B_CT, 150); push("b150_t", B_TENS, 15); push("b150_o", B_ONES, 15); drain();
    ld_val8 = 8'd99; tick();
    push("b99_t", B_TENS, 9); push("b99_o", B_ONES, 9); push("b99_err", B_ERR, 0); drain();
    ld_val8 = 8'd200; tick();
    push("b200_ct", B_CT, 199); push("b200_err", B_ERR, 1); push("b200_t", B_TENS, 15); drain();
    ld8 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
